// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM state encodings and
// the counter-width helper.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ARM_PRESS = 2'b01,
        ST_PRESSED   = 2'b10,
        ST_ARM_REL   = 2'b11
    } state_e;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, reusable for any
// KEY/SW pin; clears to 0 on synchronous reset.
module sync_2ff (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= D;
            s2_q <= s1_q;
        end
    end

    assign Q = s2_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces one raw pushbutton into a clean pressed level plus one-cycle
// press/release strobes, with an optional count-enable time base.
//
// state        | meaning
// ST_IDLE      | key released, waiting for a press
// ST_ARM_PRESS | key seen pressed, counting stable ticks before accepting
// ST_PRESSED   | key accepted as pressed
// ST_ARM_REL   | key seen released, counting stable ticks before accepting
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned STABLE_TICKS = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic IN,
    input  logic TICK,
    output logic OUT,
    output logic PRESS,
    output logic RELEASE
);

    localparam int CNT_W = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             in_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    // Polarity is fixed before synchronising so reset leaves "not pressed".
    sync_2ff u_sync (
        .CLK (CLK),
        .RST (RST),
        .D   (IN ^ ACTIVE_LOW),
        .Q   (in_s)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                out_d = 1'b0;
                if (in_s) begin
                    state_d = ST_ARM_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_ARM_PRESS: begin
                out_d = 1'b0;
                if (!in_s) begin
                    state_d = ST_IDLE;
                end else if (TICK && cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    out_d   = 1'b1;
                    press_d = 1'b1;
                end else if (TICK) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                out_d = 1'b1;
                if (!in_s) begin
                    state_d = ST_ARM_REL;
                    cnt_d   = '0;
                end
            end
            ST_ARM_REL: begin
                out_d = 1'b1;
                if (in_s) begin
                    state_d = ST_PRESSED;
                end else if (TICK && cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                    rel_d   = 1'b1;
                end else if (TICK) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = 1'b0;
            end
        endcase
    end

    assign OUT     = out_q;
    assign PRESS   = press_q;
    assign RELEASE = rel_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with STABLE_TICKS=4 and an active-low key.
module tb_key_debounce;
    import key_debounce_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    logic IN;
    logic TICK;
    logic OUT;
    logic PRESS;
    logic RELEASE;

    int n_checks = 0;
    int n_errors = 0;
    int press_cnt = 0;
    int rel_cnt = 0;
    logic prev_press = 1'b0;
    logic prev_rel = 1'b0;
    int p0, r0, p1, p2;

    key_debounce #(
        .ACTIVE_LOW   (1'b1),
        .STABLE_TICKS (4)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .IN      (IN),
        .TICK    (TICK),
        .OUT     (OUT),
        .PRESS   (PRESS),
        .RELEASE (RELEASE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Strobes are counted mid-cycle; they must be exclusive and one cycle wide.
    always @(negedge CLK) begin
        if (PRESS === 1'b1) press_cnt++;
        if (RELEASE === 1'b1) rel_cnt++;
        check("strobe_excl", 32'(PRESS & RELEASE), 32'd0);
        check("press_width", 32'(PRESS & prev_press), 32'd0);
        check("rel_width", 32'(RELEASE & prev_rel), 32'd0);
        prev_press = PRESS;
        prev_rel   = RELEASE;
    end

    initial begin
        RST  = 1'b1;
        IN   = 1'b1;
        TICK = 1'b1;
        step(3);
        check("rst_out", 32'(OUT), 32'd0);
        check("rst_press", 32'(PRESS), 32'd0);
        check("rst_release", 32'(RELEASE), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        RST = 1'b0;
        step(4);
        check("idle_out", 32'(OUT), 32'd0);

        // Clean press: new level sampled at edge k, accepted at k+6.
        p0 = press_cnt;
        IN = 1'b0;
        step(1);
        step(5);
        check("t1_out_early", 32'(OUT), 32'd0);
        check("t1_press_early", 32'(PRESS), 32'd0);
        step(1);
        check("t1_out", 32'(OUT), 32'd1);
        check("t1_press", 32'(PRESS), 32'd1);
        step(1);
        check("t1_press_end", 32'(PRESS), 32'd0);
        check("t1_out_hold", 32'(OUT), 32'd1);
        check("t1_press_cnt", 32'(press_cnt), 32'(p0 + 1));

        // Release glitch shorter than the stability window.
        r0 = rel_cnt;
        IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t6_out_glitch", 32'(OUT), 32'd1);
        end
        IN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t6_out_after", 32'(OUT), 32'd1);
        end
        check("t6_rel_cnt", 32'(rel_cnt), 32'(r0));
        check("t6_press_cnt", 32'(press_cnt), 32'(p0 + 1));

        // Clean release.
        IN = 1'b1;
        step(1);
        step(5);
        check("t3_out_early", 32'(OUT), 32'd1);
        check("t3_rel_early", 32'(RELEASE), 32'd0);
        step(1);
        check("t3_out", 32'(OUT), 32'd0);
        check("t3_rel", 32'(RELEASE), 32'd1);
        check("t3_press", 32'(PRESS), 32'd0);
        step(1);
        check("t3_rel_end", 32'(RELEASE), 32'd0);
        check("t3_rel_cnt", 32'(rel_cnt), 32'(r0 + 1));
        check("t3_press_cnt", 32'(press_cnt), 32'(p0 + 1));

        // Bounce: toggle every 2 cycles for 20 cycles, then hold pressed.
        p1 = press_cnt;
        for (int i = 0; i < 20; i++) begin
            IN = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
            check("t2_out_bounce", 32'(OUT), 32'd0);
        end
        IN = 1'b0;
        step(1);
        check("t2_no_press_bounce", 32'(press_cnt), 32'(p1));
        step(5);
        check("t2_out_early", 32'(OUT), 32'd0);
        step(1);
        check("t2_press", 32'(PRESS), 32'd1);
        check("t2_out", 32'(OUT), 32'd1);
        step(1);
        check("t2_press_cnt", 32'(press_cnt), 32'(p1 + 1));
        IN = 1'b1;
        step(8);
        check("t2_released", 32'(OUT), 32'd0);

        // TICK every 8th cycle: accept on the 4th qualified cycle in ARM_PRESS.
        TICK = 1'b0;
        IN = 1'b0;
        step(1);
        for (int j = 1; j <= 32; j++) begin
            TICK = (j % 8 == 0);
            step(1);
            if (j == 24) check("t4_out_3rd_tick", 32'(OUT), 32'd0);
            if (j == 31) begin
                check("t4_out_early", 32'(OUT), 32'd0);
                check("t4_press_early", 32'(PRESS), 32'd0);
            end
            if (j == 32) begin
                check("t4_out", 32'(OUT), 32'd1);
                check("t4_press", 32'(PRESS), 32'd1);
            end
        end
        TICK = 1'b1;
        IN = 1'b1;
        step(8);
        check("t4_released", 32'(OUT), 32'd0);

        // Reset while arming with cnt=2; held key re-arms from scratch.
        p2 = press_cnt;
        IN = 1'b0;
        step(1);
        step(4);
        check("t5_state_arm", 32'(dut.state_q), 32'(ST_ARM_PRESS));
        check("t5_cnt", 32'(dut.cnt_q), 32'd2);
        RST = 1'b1;
        step(1);
        check("t5_out_rst", 32'(OUT), 32'd0);
        check("t5_press_rst", 32'(PRESS), 32'd0);
        check("t5_state_rst", 32'(dut.state_q), 32'(ST_IDLE));
        RST = 1'b0;
        step(6);
        check("t5_out_early", 32'(OUT), 32'd0);
        check("t5_press_early", 32'(PRESS), 32'd0);
        step(1);
        check("t5_press", 32'(PRESS), 32'd1);
        check("t5_out", 32'(OUT), 32'd1);
        step(1);
        check("t5_press_cnt", 32'(press_cnt), 32'(p2 + 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
